// File: rtl/mem_resp.sv
// Fixed-latency memory responder shared by the fetch and load/store ports.
// One request in flight at a time; LSU wins when both ports ask together.
module mem_resp #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wbmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        busy
);

  localparam int          IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          port_lsu;
  logic [31:0]   rdata_q;

  logic          sel_lsu, accept, is_wr, in_range;
  logic [31:0]   req_addr, word_off, rd_word, rd_val, wdata_sh;
  logic [1:0]    off;
  logic [IW-1:0] idx;
  logic [3:0]    wmask;

  assign sel_lsu  = lsu_reqValid;
  assign accept   = (state == S_IDLE) && (lsu_reqValid || ifu_reqValid);
  assign req_addr = sel_lsu ? lsu_addr : ifu_addr;
  assign is_wr    = sel_lsu && lsu_wen;

  // Subtraction wraps for addresses below base, so the base compare is explicit.
  assign word_off = req_addr - BASE_ADDR;
  assign in_range = (req_addr >= BASE_ADDR) && (word_off[31:2] < DEPTH_W30);
  assign idx      = word_off[IW+1:2];
  assign off      = word_off[1:0];

  assign rd_word  = mem[idx];
  assign rd_val   = (is_wr || !in_range) ? 32'h0 : (rd_word >> {off, 3'b000});
  // Lanes shifted beyond the word boundary fall off the 4-bit mask.
  assign wmask    = lsu_wbmask << off;
  assign wdata_sh = lsu_wdata << {off, 3'b000};

  always_ff @(posedge clock) begin
    if (accept && is_wr && in_range) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      port_lsu  <= 1'b0;
      rdata_q   <= '0;
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          port_lsu <= sel_lsu;
          rdata_q  <= rd_val;
          if (LATENCY == 1) begin
            state <= S_RESP;
            if (sel_lsu) lsu_rdata <= rd_val;
            else         ifu_rdata <= rd_val;
          end else begin
            state <= S_WAIT;
            cnt   <= LAT_M1;
          end
        end
        S_WAIT: if (cnt == 4'd1) begin
          state <= S_RESP;
          if (port_lsu) lsu_rdata <= rdata_q;
          else          ifu_rdata <= rdata_q;
        end else begin
          cnt <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (state != S_IDLE);
  assign ifu_respValid = (state == S_RESP) && !port_lsu;
  assign lsu_respValid = (state == S_RESP) &&  port_lsu;

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: directed vector table, reset/arbitration sequences,
// then random traffic checked against a byte-addressed memory model.
module tb_mem_resp;

  localparam int          DEPTH   = 4096;
  localparam int          LAT     = 2;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam logic [31:0] OOR_HI  = 32'h8000_4000;
  localparam logic [31:0] LAST_W  = 32'h8000_3FFC;

  logic        clock, reset;
  logic        ifu_reqValid, ifu_respValid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_reqValid, lsu_wen, lsu_respValid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wbmask;
  logic        busy;

  mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wbmask(lsu_wbmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory as individual bytes; loads return the bytes from addr to the end of its word.
  logic [7:0] mb [longint];

  function automatic bit in_rng(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    longint      ua;
    r  = 32'h0;
    ua = longint'(a);
    if (!in_rng(a)) return 32'h0;
    for (int i = 0; i < 4 - int'(ua % 4); i++)
      r[8*i +: 8] = mb.exists(ua + i) ? mb[ua + i] : 8'hxx;
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    longint ua;
    ua = longint'(a);
    if (!in_rng(a)) return;
    for (int i = 0; i < 4; i++)
      if (m[i] && (int'(ua % 4) + i < 4)) mb[ua + i] = d[8*i +: 8];
  endtask

  // Issue one solo request; report data, response cycle count, stray strobe and stretched strobe.
  task automatic do_req(input bit lsu, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output logic [31:0] rd, output int lat,
                        output bit other, output bit stretched);
    @(negedge clock);
    lat = -1; other = 1'b0; stretched = 1'b0; rd = 32'hx;
    if (lsu) begin
      lsu_reqValid = 1'b1; lsu_wen = wen; lsu_addr = addr;
      lsu_wdata = wdata; lsu_wbmask = mask;
    end else begin
      ifu_reqValid = 1'b1; ifu_addr = addr;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (lsu ? ifu_respValid : lsu_respValid) other = 1'b1;
      if (lsu ? lsu_respValid : ifu_respValid) begin
        lat = k;
        rd  = lsu ? lsu_rdata : ifu_rdata;
        break;
      end
    end
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    @(negedge clock);
    if (lsu ? lsu_respValid : ifu_respValid) stretched = 1'b1;
  endtask

  task automatic run(input string name, input bit lsu, input bit wen,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] mask, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    bit          other, stretched;
    do_req(lsu, wen, addr, wdata, mask, rd, lat, other, stretched);
    chk({name, " rdata"}, rd, exp);
    chk({name, " latency"}, 32'(lat), 32'(LAT));
    chk({name, " other strobe"}, {31'b0, other}, 32'h0);
    chk({name, " strobe width"}, {31'b0, stretched}, 32'h0);
    if (lsu && wen) model_write(addr, wdata, mask);
  endtask

  typedef struct {
    bit          lsu;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] last_ifu, ifu_before, lrd, ird;
    int          lk, ik, lcnt, icnt;

    tbl.push_back('{1, 1, BASE,          32'hDEADBEEF, 4'hF,    32'h0});
    tbl.push_back('{0, 0, BASE,          32'h0,        4'h0,    32'hDEADBEEF});
    tbl.push_back('{1, 1, 32'h8000_0004, 32'h11223344, 4'hF,    32'h0});
    tbl.push_back('{1, 0, 32'h8000_0006, 32'h0,        4'h0,    32'h00001122});
    tbl.push_back('{1, 0, 32'h8000_0007, 32'h0,        4'h0,    32'h00000011});
    tbl.push_back('{1, 1, 32'h8000_0008, 32'h0,        4'hF,    32'h0});
    tbl.push_back('{1, 1, 32'h8000_000A, 32'h000000AB, 4'b0001, 32'h0});
    tbl.push_back('{1, 0, 32'h8000_0008, 32'h0,        4'h0,    32'h00AB0000});
    tbl.push_back('{1, 1, 32'h8000_000B, 32'h0000CDEF, 4'b0011, 32'h0});
    tbl.push_back('{1, 0, 32'h8000_0008, 32'h0,        4'h0,    32'hEFAB0000});
    tbl.push_back('{1, 1, LAST_W,        32'hCAFEF00D, 4'hF,    32'h0});
    tbl.push_back('{1, 0, 32'h7FFF_FFFC, 32'h0,        4'h0,    32'h0});
    tbl.push_back('{1, 0, OOR_HI,        32'h0,        4'h0,    32'h0});
    tbl.push_back('{1, 1, 32'h7FFF_FFFC, 32'h12345678, 4'hF,    32'h0});
    tbl.push_back('{1, 1, OOR_HI,        32'h12345678, 4'hF,    32'h0});
    tbl.push_back('{1, 0, BASE,          32'h0,        4'h0,    32'hDEADBEEF});
    tbl.push_back('{0, 0, LAST_W,        32'h0,        4'h0,    32'hCAFEF00D});
    tbl.push_back('{0, 0, 32'h8000_0005, 32'h0,        4'h0,    32'h00112233});

    reset = 1'b1;
    ifu_reqValid = 1'b0; ifu_addr = '0;
    lsu_reqValid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wbmask = '0;
    repeat (2) @(negedge clock);
    chk("reset busy",          {31'b0, busy},          32'h0);
    chk("reset ifu_respValid", {31'b0, ifu_respValid}, 32'h0);
    chk("reset lsu_respValid", {31'b0, lsu_respValid}, 32'h0);
    chk("reset ifu_rdata",     ifu_rdata,              32'h0);
    chk("reset lsu_rdata",     lsu_rdata,              32'h0);
    reset = 1'b0;

    foreach (tbl[i])
      run($sformatf("vec%0d", i), tbl[i].lsu, tbl[i].wen, tbl[i].addr,
          tbl[i].wdata, tbl[i].mask, tbl[i].exp);
    last_ifu = 32'h00112233;

    // Asynchronous reset while a fetch is waiting for its response.
    @(negedge clock);
    ifu_reqValid = 1'b1; ifu_addr = BASE;
    @(negedge clock);
    chk("busy after accept", {31'b0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy",     {31'b0, busy},          32'h0);
    chk("async reset ifu_resp", {31'b0, ifu_respValid}, 32'h0);
    chk("async reset lsu_resp", {31'b0, lsu_respValid}, 32'h0);
    chk("async reset ifu_rdata", ifu_rdata,             32'h0);
    ifu_reqValid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    icnt = 0;
    repeat (4) begin
      @(negedge clock);
      if (ifu_respValid || lsu_respValid) icnt++;
    end
    chk("no strobe after reset", 32'(icnt), 32'h0);
    run("post-reset fetch", 1'b0, 1'b0, BASE, 32'h0, 4'h0, 32'hDEADBEEF);
    last_ifu = 32'hDEADBEEF;

    // Both ports request together: LSU first, IFU after the LSU round trip.
    @(negedge clock);
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0005;
    lsu_reqValid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0004;
    lk = -1; ik = -1; lcnt = 0; icnt = 0; lrd = 'x; ird = 'x; ifu_before = 'x;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (lsu_respValid) begin
        lcnt++;
        if (lk < 0) begin lk = k; lrd = lsu_rdata; ifu_before = ifu_rdata; end
        lsu_reqValid = 1'b0;
      end
      if (ifu_respValid) begin
        icnt++;
        if (ik < 0) begin ik = k; ird = ifu_rdata; end
        ifu_reqValid = 1'b0;
      end
    end
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    chk("simul lsu latency",   32'(lk),    32'(LAT));
    chk("simul ifu latency",   32'(ik),    32'(2 * LAT + 1));
    chk("simul lsu rdata",     lrd,        32'h11223344);
    chk("simul ifu rdata",     ird,        32'h00112233);
    chk("simul ifu untouched", ifu_before, last_ifu);
    chk("simul lsu strobes",   32'(lcnt),  32'h1);
    chk("simul ifu strobes",   32'(icnt),  32'h1);

    // Random traffic over words 0..15, with occasional out-of-range addresses.
    for (int w = 0; w < 16; w++)
      run($sformatf("init%0d", w), 1'b1, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, 32'h0);
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, d, e;
      logic [3:0]  m;
      bit          lsu, wen;
      lsu = ($urandom_range(0, 3) != 0);
      wen = lsu && ($urandom_range(0, 1) == 1);
      a   = BASE + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 1) ? (BASE - 32'($urandom_range(1, 64)))
                                        : (OOR_HI + 32'($urandom_range(0, 64)));
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      e = wen ? 32'h0 : model_read(a);
      run($sformatf("rnd%0d", n), lsu, wen, a, d, m, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_resp.md
# mem_resp

Memory responder for the core's request/response handshake: serves the instruction-fetch port and the load/store port from one shared word array. Each accepted request is answered with a single-cycle `respValid` after a fixed latency. Byte-lane alignment is applied on both reads and writes, so the core sees load data in the low bits and can write sub-word stores with a 4-bit mask. Sits between the core's fetch/LSU request ports and the storage.

## Interface
- `DEPTH_WORDS`, 4096: number of 32-bit words in the array.
- `LATENCY`, 2: cycles from accept edge to the `respValid` cycle; legal range 1..15.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ifu_reqValid`  in  1  fetch request; held high by the requester until `ifu_respValid`.
- `ifu_addr`  in  32  fetch byte address.
- `ifu_respValid`  out  1  one-cycle fetch response strobe.
- `ifu_rdata`  out  32  fetch data; valid while `ifu_respValid`, held afterwards.
- `lsu_reqValid`  in  1  load/store request; held until `lsu_respValid`.
- `lsu_wen`  in  1  1 = store, 0 = load.
- `lsu_addr`  in  32  byte address.
- `lsu_wdata`  in  32  store data, unaligned (low bytes hold the data).
- `lsu_wbmask`  in  4  store byte mask, unaligned (bit 0 = `lsu_wdata[7:0]`).
- `lsu_respValid`  out  1  one-cycle load/store response strobe.
- `lsu_rdata`  out  32  load data, right-aligned; held afterwards.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- **Accepting a request.** A request is accepted only in IDLE.
  - LSU has fixed priority. If both `reqValid` are high, LSU is accepted and IFU stays pending.
  - On the accept edge the block latches the port id and the word index `(addr-BASE_ADDR)>>2`.
  - It also latches the byte offset `off = addr[1:0]`.
- **Reads** (IFU, or LSU with `lsu_wen=0`).
  - On the accept edge: `rdata_q <= mem[idx] >> (8*off)`. Upper bytes are zero-filled; the core sign-extends.
- **Writes** (LSU with `lsu_wen=1`).
  - Committed on the accept edge.
  - Shifted mask is `m = (lsu_wbmask << off)[3:0]`; shifted data is `(lsu_wdata << 8*off)`.
  - Lanes shifted past bit 31 are dropped.
  - Only lanes with `m[i]=1` are written.
  - A store response carries `rdata = 0`.
- **Out of range.** The index is out of range if `addr < BASE_ADDR` or `idx >= DEPTH_WORDS`.
  - Reads return 0.
  - Writes are ignored.
  - A response is still given.
- **Transitions.**
  - IDLE→WAIT on accept with a counter loaded to LATENCY-1.
  - IDLE→RESP on accept when LATENCY=1.
  - WAIT decrements; at count 1 it moves to RESP.
  - RESP→IDLE unconditionally.
- **Response outputs.**
  - In RESP, the latched port's `respValid` = 1 for exactly one cycle.
  - That port's `rdata` output register is updated from `rdata_q` on entry to RESP.
  - The other port's `rdata` is unchanged.
- **No ready signal.**
  - A request not accepted in a given cycle simply stays pending, since the requester holds `reqValid`.
  - Any `reqValid` sampled outside IDLE is ignored.
- Array contents are not reset or initialised by the block.

## Timing
- Reset values: state IDLE, `ifu_respValid=0`, `lsu_respValid=0`, `ifu_rdata=0`, `lsu_rdata=0`, `busy=0`.
- Reset mid-operation: the pending response is dropped and no strobe is issued. A store already committed stays in the array.
- Accept on edge E0 gives `respValid` high in the cycle following edge E0+LATENCY-1, i.e. LATENCY cycles after E0.
- The earliest next accept is the IDLE cycle after RESP. Back-to-back request period is LATENCY+1 cycles.
- A store followed by a load to the same word, through the same or the other port, returns the new data.
- `busy` is registered with the state and goes high the cycle after the accept edge.
- Both ports request in IDLE: LSU responds at E0+LATENCY. IFU is accepted at the IDLE edge after RESP and responds LATENCY+1 cycles later.

## Test plan
- **Reset mid-request.** Raise `reset` asynchronously during WAIT → both `respValid` go to 0 immediately. After release, IDLE; a fresh fetch completes normally.
- **LATENCY=2 fetch.** Preload word 0 = 32'hDEADBEEF; IFU request at 32'h8000_0000 → `ifu_respValid` high exactly 2 cycles after accept, `ifu_rdata`=32'hDEADBEEF. `lsu_respValid` stays 0.
- **Byte and half loads.** Word 1 = 32'h11223344; LSU load from 32'h8000_0006 → `lsu_rdata`=32'h00001122. Load from 32'h8000_0007 → 32'h00000011.
- **Masked store.** Word 2 = 0; store `wdata`=32'h000000AB, `wbmask`=4'b0001 at 32'h8000_000A. Read back word 2 → 32'h00AB0000. A half store (`wbmask`=4'b0011) at offset 3 → only byte 3 written.
- **Simultaneous requests.** Both ports request in the same cycle → LSU responds first, IFU one cycle later than a solo IFU request plus LATENCY. Each port receives its own data, never the other's.
- **Out of range.** Load from 32'h7FFF_FFFC and from `BASE_ADDR+4*DEPTH_WORDS` → response given with `rdata`=0. A store to the same addresses leaves the array unchanged; verify by reading back word 0 and the last word.
